// File: rtl/qfix_pkg.sv
// Shared fixed-point definitions: default Q format, MAC control states and a
// generic sign-magnitude add used by the accumulator datapath.
package qfix_pkg;

    localparam int Q_DEF = 16;
    localparam int N_DEF = 32;
    localparam int G_DEF = 4;
    localparam int SM_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic            sign;
        logic [SM_W-1:0] mag;
        logic            carry;
    } sm_sum_t;

    // Wide sign-magnitude add; callers narrow the magnitude and test carry/upper bits.
    function automatic sm_sum_t sm_add(input logic            a_sign,
                                       input logic [SM_W-1:0] a_mag,
                                       input logic            b_sign,
                                       input logic [SM_W-1:0] b_mag);
        sm_sum_t       r;
        logic [SM_W:0] s;
        if (a_sign == b_sign) begin
            s      = {1'b0, a_mag} + {1'b0, b_mag};
            r.sign = a_sign;
        end else if (a_mag >= b_mag) begin
            s      = {1'b0, a_mag - b_mag};
            r.sign = a_sign;
        end else begin
            s      = {1'b0, b_mag - a_mag};
            r.sign = b_sign;
        end
        r.mag   = s[SM_W-1:0];
        r.carry = s[SM_W];
        if (r.mag == '0 && !r.carry) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/qadd_sm.sv
// Combinational sign-magnitude adder of width W that clamps the magnitude to
// all ones (and flags it) when the true sum does not fit.
module qadd_sm
    import qfix_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         i_a_sign,
    input  logic [W-1:0] i_a_mag,
    input  logic         i_b_sign,
    input  logic [W-1:0] i_b_mag,
    output logic         o_sign,
    output logic [W-1:0] o_mag,
    output logic         o_sat
);

    sm_sum_t r;

    // W must stay below SM_W so bit W of the wide sum reveals overflow.
    always_comb begin
        r      = sm_add(i_a_sign, SM_W'(i_a_mag), i_b_sign, SM_W'(i_b_mag));
        o_sat  = r.carry | (|r.mag[SM_W-1:W]);
        o_sign = r.sign;
        o_mag  = o_sat ? '1 : r.mag[W-1:0];
    end

endmodule

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier: truncates the product back to Q format
// and flags any magnitude bits lost above the N-1 bit result.
module qmult #(
    parameter int Q = 16,
    parameter int N = 32
) (
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic [N-1:0] o_result,
    output logic         ovr
);

    logic [2*N-3:0] full_mag;
    logic           unused_lsb;

    assign full_mag   = i_multiplicand[N-2:0] * i_multiplier[N-2:0];
    assign o_result   = {i_multiplicand[N-1] ^ i_multiplier[N-1], full_mag[N-2+Q:Q]};
    assign ovr        = |full_mag[2*N-3:N-1+Q];
    assign unused_lsb = ^full_mag[Q-1:0];

endmodule

// File: rtl/qmac_accum.sv
// Sequential sign-magnitude multiply-accumulate: streams i_len operand pairs
// through qmult, sums them in a guarded accumulator and emits one saturated result.
module qmac_accum
    import qfix_pkg::*;
#(
    parameter int Q  = Q_DEF,
    parameter int N  = N_DEF,
    parameter int G  = G_DEF,
    parameter int LW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_result,
    output logic          o_ovr,
    output logic          o_done,
    output logic          o_busy
);

    localparam int AW = N - 1 + G;

    state_t        state_q;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] len_q;
    logic          acc_sign_q;
    logic [AW-1:0] acc_mag_q;
    logic          ovr_q;
    logic          done_q;
    logic          busy_q;
    logic [N-1:0]  result_q;

    logic          vld_p1_q;
    logic          prod_sign_p1_q;
    logic [N-2:0]  prod_mag_p1_q;
    logic          prod_ovr_p1_q;

    logic [N-1:0]  mult_res;
    logic          mult_ovr;
    logic          xfer;
    logic          last_term;
    logic          acc_sign_d;
    logic [AW-1:0] acc_mag_d;
    logic          acc_sat_d;
    logic [N:0]    out_d;

    // Returns {overflow, result}; magnitudes beyond N-1 bits saturate, zero is always +0.
    function automatic logic [N:0] sat_out(input logic sign, input logic [AW-1:0] mag);
        if (|mag[AW-1:N-1]) begin
            return {1'b1, sign, {(N-1){1'b1}}};
        end else if (mag[N-2:0] == '0) begin
            return '0;
        end else begin
            return {1'b0, sign, mag[N-2:0]};
        end
    endfunction

    assign xfer      = i_valid && (state_q == RUN);
    assign last_term = (cnt_q == len_q - LW'(1));
    assign out_d     = sat_out(acc_sign_q, acc_mag_q);

    qmult #(
        .Q(Q),
        .N(N)
    ) u_mult (
        .i_multiplicand(i_a),
        .i_multiplier  (i_b),
        .o_result      (mult_res),
        .ovr           (mult_ovr)
    );

    // Stage p1: registered product, with a zero magnitude forced positive.
    always_ff @(posedge i_clk) begin
        if (xfer) begin
            prod_sign_p1_q <= mult_res[N-1] & (|mult_res[N-2:0]);
            prod_mag_p1_q  <= mult_res[N-2:0];
            prod_ovr_p1_q  <= mult_ovr;
        end
    end

    qadd_sm #(
        .W(AW)
    ) u_add (
        .i_a_sign(acc_sign_q),
        .i_a_mag (acc_mag_q),
        .i_b_sign(prod_sign_p1_q),
        .i_b_mag ({{G{1'b0}}, prod_mag_p1_q}),
        .o_sign  (acc_sign_d),
        .o_mag   (acc_mag_d),
        .o_sat   (acc_sat_d)
    );

    // Stage p2: accumulator update; control FSM and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            acc_sign_q <= 1'b0;
            acc_mag_q  <= '0;
            ovr_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            result_q   <= '0;
            vld_p1_q   <= 1'b0;
        end else begin
            vld_p1_q <= xfer;
            done_q   <= 1'b0;
            if (vld_p1_q) begin
                acc_sign_q <= acc_sign_d;
                acc_mag_q  <= acc_mag_d;
                if (prod_ovr_p1_q || acc_sat_d) begin
                    ovr_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        cnt_q      <= '0;
                        len_q      <= i_len;
                        acc_sign_q <= 1'b0;
                        acc_mag_q  <= '0;
                        ovr_q      <= 1'b0;
                        if (i_len != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q  <= DONE;
                            result_q <= '0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + LW'(1);
                        if (last_term) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last product has been folded into acc once p1 is empty.
                    if (!vld_p1_q) begin
                        state_q  <= DONE;
                        result_q <= out_d[N-1:0];
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        if (out_d[N]) begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready  = (state_q == RUN);
    assign o_result = result_q;
    assign o_ovr    = ovr_q;
    assign o_done   = done_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_qmac_accum.sv
// Bench for qmac_accum: directed Q16.16 cases plus randomized runs compared
// against an integer-arithmetic reference of the multiply-accumulate.
module tb_qmac_accum;

    localparam longint OUT_MAX = 64'd2147483647;
    localparam longint ACC_MAX = 64'd34359738367;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_len = '0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] o_result;
    logic        o_ovr;
    logic        o_done;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    qmac_accum #(
        .Q (16),
        .N (32),
        .G (4),
        .LW(8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_len   (i_len),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_result(o_result),
        .o_ovr   (o_ovr),
        .o_done  (o_done),
        .o_busy  (o_busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int ready_viol = 0;
    int done_cnt = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always @(negedge i_clk) begin
        if (o_ready && !o_busy) ready_viol++;
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: exact integer products, truncated to Q16.16, summed as signed values.
    function automatic void ref_run(output logic [31:0] res, output logic ovr);
        longint acc;
        longint pm;
        longint mag;
        acc = 0;
        ovr = 1'b0;
        foreach (qa[i]) begin
            pm = (longint'(qa[i][30:0]) * longint'(qb[i][30:0])) / 65536;
            if (pm > OUT_MAX) begin
                ovr = 1'b1;
                pm  = pm % (OUT_MAX + 1);
            end
            acc = (qa[i][31] ^ qb[i][31]) ? acc - pm : acc + pm;
            if (acc > ACC_MAX) begin
                acc = ACC_MAX;
                ovr = 1'b1;
            end else if (acc < -ACC_MAX) begin
                acc = -ACC_MAX;
                ovr = 1'b1;
            end
        end
        mag = (acc < 0) ? -acc : acc;
        if (mag > OUT_MAX) begin
            ovr = 1'b1;
            res = {(acc < 0), 31'h7FFFFFFF};
        end else begin
            res = {(acc < 0), mag[30:0]};
        end
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    // mode 0: back-to-back, 1: valid toggling, 2: random gaps. poke pulses i_start mid-run.
    task automatic do_run(input int len, input int mode, input bit poke, output int lat);
        int idx;
        int guard;
        logic v;
        logic rdy;
        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = len[7:0];
        @(negedge i_clk);
        i_start = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < len && guard < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            i_valid = v;
            i_a     = qa[idx];
            i_b     = qb[idx];
            if (poke && idx == 1) begin
                i_start = 1'b1;
                i_len   = 8'd3;
            end else begin
                i_start = 1'b0;
            end
            rdy = o_ready;
            @(negedge i_clk);
            if (v && rdy) idx++;
            guard++;
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        check("feed_count", idx, len);
        lat = 0;
        while (!o_done && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input int len, input int mode, input bit poke,
                             input bit use_exp, input logic [31:0] exp_res, input logic exp_ovr);
        int lat;
        logic [31:0] r_res;
        logic r_ovr;
        ref_run(r_res, r_ovr);
        if (use_exp) begin
            r_res = exp_res;
            r_ovr = exp_ovr;
        end
        do_run(len, mode, poke, lat);
        check({tag, "_latency"}, lat, (len == 0) ? 0 : 2);
        check({tag, "_result"}, o_result, r_res);
        check({tag, "_ovr"}, {31'd0, o_ovr}, {31'd0, r_ovr});
        @(negedge i_clk);
        check({tag, "_done_pulse"}, {30'd0, o_done, o_busy}, 32'd0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        int done_before;
        #1 i_rst = 1'b1;
        #11;
        check("reset_outputs", {27'd0, o_ready, o_busy, o_done, o_ovr, |o_result}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        push(32'h00018000, 32'h00020000);
        push(32'h80010000, 32'h00008000);
        run_check("mixed_sign_poke", 2, 0, 1'b1, 1'b1, 32'h00028000, 1'b0);

        push(32'h00010000, 32'h00010000);
        push(32'h80010000, 32'h00010000);
        run_check("cancel", 2, 0, 1'b0, 1'b1, 32'h00000000, 1'b0);

        for (int i = 0; i < 16; i++) push(32'h40000000, 32'h00010000);
        run_check("out_sat", 16, 1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);
        check("ready_outside_run", ready_viol, 0);

        push(32'h7FFF0000, 32'h00020000);
        run_check("prod_ovr", 1, 0, 1'b0, 1'b1, 32'h7FFE0000, 1'b1);
        push(32'h00010000, 32'h00010000);
        run_check("after_ovr", 1, 0, 1'b0, 1'b1, 32'h00010000, 1'b0);

        push(32'h80000000, 32'h00010000);
        run_check("neg_zero", 1, 0, 1'b0, 1'b1, 32'h00000000, 1'b0);

        run_check("zero_len", 0, 0, 1'b0, 1'b1, 32'h00000000, 1'b0);

        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = 8'd8;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) begin
            i_valid = 1'b1;
            i_a     = 32'h00010000;
            i_b     = 32'h00010000;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        done_before = done_cnt;
        #2 i_rst = 1'b1;
        #1;
        check("reset_mid_run", {27'd0, o_ready, o_busy, o_done, o_ovr, |o_result}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (6) @(negedge i_clk);
        check("no_done_after_reset", done_cnt, done_before);
        push(32'h00010000, 32'h00010000);
        run_check("after_reset", 1, 0, 1'b0, 1'b1, 32'h00010000, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                logic [31:0] a;
                a = $urandom & 32'h80FFFFFF;
                if ($urandom_range(0, 7) == 0) a = 32'h80000000;
                push(a, $urandom & 32'h8003FFFF);
            end
            run_check("random", len, 2, 1'b0, 1'b0, 32'd0, 1'b0);
        end

        for (int i = 0; i < 200; i++) push($urandom & 32'h7FFFFFFF, 32'h00010000 | ($urandom & 32'h0000FFFF));
        run_check("acc_clamp", 200, 0, 1'b0, 1'b0, 32'd0, 1'b0);

        check("ready_outside_run_final", ready_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
